// File: rtl/breakout_pkg.sv
// -----------------------------------------------------------------------------
// breakout_pkg
// Shared definitions for the Breakout screen/level state machine and the
// blocks that feed it.
//   - Screen and level encodings carried on the level FSM's current_state bus.
//   - bricks_for(n): brick count for level index n (1..8).
//   - is_level(state): true when the state encoding is one of L1..L8.
// -----------------------------------------------------------------------------
package breakout_pkg;

    // Screen encodings
    localparam logic [3:0] ST_SM = 4'hF;
    localparam logic [3:0] ST_LS = 4'h1;
    localparam logic [3:0] ST_GO = 4'h2;

    // Level encodings; level index n = state - 2
    localparam logic [3:0] ST_L1 = 4'h3;
    localparam logic [3:0] ST_L2 = 4'h4;
    localparam logic [3:0] ST_L3 = 4'h5;
    localparam logic [3:0] ST_L4 = 4'h6;
    localparam logic [3:0] ST_L5 = 4'h7;
    localparam logic [3:0] ST_L6 = 4'h8;
    localparam logic [3:0] ST_L7 = 4'h9;
    localparam logic [3:0] ST_L8 = 4'hA;

    function automatic logic is_level(input logic [3:0] state);
        return (state >= ST_L1) && (state <= ST_L8);
    endfunction

    // Brick count per level index. Every entry is nonzero, so a freshly
    // loaded level can never be "already won".
    function automatic logic [5:0] bricks_for(input logic [3:0] n);
        case (n)
            4'd1:    return 6'd8;
            4'd2:    return 6'd12;
            4'd3:    return 6'd16;
            4'd4:    return 6'd20;
            4'd5:    return 6'd24;
            4'd6:    return 6'd28;
            4'd7:    return 6'd32;
            4'd8:    return 6'd40;
            default: return 6'd8;
        endcase
    endfunction

endpackage

// File: rtl/game_status.sv
// -----------------------------------------------------------------------------
// game_status
// Per-level play statistics for Breakout. Loads brick count and lives when the
// level FSM enters a level, counts brick hits and ball losses, accumulates a
// saturating score and produces the win/lose outcome back to the level FSM.
//
// Parameters
//   LIVES     lives granted at each level start (1..7)
//   SERVE_DLY cycles between a ball loss and the re-serve (>=1)
//   SCORE_W   score width (>=4)
// Ports
//   clk           system clock
//   reset         synchronous, active-high
//   current_state level FSM state encoding (breakout_pkg)
//   brick_hit     one-cycle pulse per destroyed brick
//   ball_lost     one-cycle pulse when the ball passes the paddle
//   win / lose    outcome, held until the level FSM leaves the level
//   lives         remaining lives
//   bricks_left   bricks remaining in the current level
//   score         accumulated score, cleared on the start-menu screen
//   serve_req     one-cycle pulse requesting a new ball serve
// All outputs are registered.
// -----------------------------------------------------------------------------
module game_status
    import breakout_pkg::*;
#(
    parameter int LIVES     = 3,
    parameter int SERVE_DLY = 16,
    parameter int SCORE_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         current_state,
    input  logic               brick_hit,
    input  logic               ball_lost,
    output logic               win,
    output logic               lose,
    output logic [2:0]         lives,
    output logic [5:0]         bricks_left,
    output logic [SCORE_W-1:0] score,
    output logic               serve_req
);

    localparam int CNT_W = $clog2(SERVE_DLY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_RESPAWN,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [3:0]         level_reg;   // level index latched on entry
    logic [CNT_W-1:0]   cnt_reg;     // respawn countdown

    logic               in_level;
    logic               hit_ok;
    logic               score_en;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    assign in_level  = is_level(current_state);
    // A hit with no bricks left is dropped so bricks_left cannot underflow.
    assign hit_ok    = brick_hit && (bricks_left != 6'd0);
    assign score_en  = in_level && (state_reg == S_PLAY) && hit_ok;
    // One extra bit catches the carry so the score sticks at all-ones.
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(level_reg);
    assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            level_reg   <= '0;
            cnt_reg     <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
            serve_req   <= 1'b0;
            lives       <= '0;
            bricks_left <= '0;
            score       <= '0;
        end else begin
            serve_req <= 1'b0;

            if (!in_level) begin
                // Leaving the level from any state: lives and bricks_left
                // hold so screens can still show them.
                state_reg <= S_IDLE;
                win       <= 1'b0;
                lose      <= 1'b0;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        win       <= 1'b0;
                        lose      <= 1'b0;
                        level_reg <= current_state - 4'd2;
                        state_reg <= S_LOAD;
                    end
                    S_LOAD: begin
                        bricks_left <= bricks_for(level_reg);
                        lives       <= 3'(LIVES);
                        serve_req   <= 1'b1;
                        state_reg   <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (hit_ok) begin
                            bricks_left <= bricks_left - 6'd1;
                        end
                        // The brick is counted before the loss: clearing the
                        // last brick wins outright and the loss is dropped.
                        if (hit_ok && bricks_left == 6'd1) begin
                            win       <= 1'b1;
                            state_reg <= S_DONE;
                        end else if (ball_lost) begin
                            lives <= lives - 3'd1;
                            if (lives == 3'd1) begin
                                lose      <= 1'b1;
                                state_reg <= S_DONE;
                            end else begin
                                cnt_reg   <= CNT_W'(SERVE_DLY);
                                state_reg <= S_RESPAWN;
                            end
                        end
                    end
                    S_RESPAWN: begin
                        // SERVE_DLY decrements plus one terminal cycle, so the
                        // serve appears SERVE_DLY+1 edges after the loss edge.
                        if (cnt_reg == '0) begin
                            serve_req <= 1'b1;
                            state_reg <= S_PLAY;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        // Outcome held until the level FSM leaves the level.
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end

            if (current_state == ST_SM) begin
                score <= '0;
            end else if (score_en) begin
                score <= score_sat;
            end
        end
    end

endmodule

// File: tb/tb_game_status.sv
// -----------------------------------------------------------------------------
// tb_game_status
// Self-checking bench for game_status. The bench plays the role of the level
// FSM and the collision logic. Expected values come from a play-level model:
// a ball is "in play" only strictly after its serve edge, lives/bricks/score
// are plain integers, and each loss schedules the next serve edge.
// -----------------------------------------------------------------------------
module tb_game_status;

    localparam int LIVES     = 3;
    localparam int SERVE_DLY = 16;
    localparam int SCORE_W   = 8;
    localparam int SMAX      = 255;

    localparam logic [3:0] SM = 4'hF;
    localparam logic [3:0] LS = 4'h1;
    localparam logic [3:0] GO = 4'h2;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         current_state;
    logic               brick_hit;
    logic               ball_lost;
    logic               win;
    logic               lose;
    logic [2:0]         lives;
    logic [5:0]         bricks_left;
    logic [SCORE_W-1:0] score;
    logic               serve_req;

    game_status #(
        .LIVES     (LIVES),
        .SERVE_DLY (SERVE_DLY),
        .SCORE_W   (SCORE_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .current_state (current_state),
        .brick_hit     (brick_hit),
        .ball_lost     (ball_lost),
        .win           (win),
        .lose          (lose),
        .lives         (lives),
        .bricks_left   (bricks_left),
        .score         (score),
        .serve_req     (serve_req)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int serve_due = -1;   // edge number after which serve_req must be high

    // Play-level model
    int m_lives  = 0;
    int m_bricks = 0;
    int m_score  = 0;
    int m_level  = 0;
    bit m_win    = 0;
    bit m_lose   = 0;
    bit m_active = 0;
    bit m_done   = 0;
    int tbl [1:8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("serve_req", 32'(serve_req), 32'(cyc == serve_due));
        chk("win_lose_excl", 32'(win & lose), 32'd0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".lives"},  32'(lives),       32'(m_lives));
        chk({tag, ".bricks"}, 32'(bricks_left), 32'(m_bricks));
        chk({tag, ".score"},  32'(score),       32'(m_score));
        chk({tag, ".win"},    32'(win),         32'(m_win));
        chk({tag, ".lose"},   32'(lose),        32'(m_lose));
    endtask

    task automatic set_screen(input logic [3:0] s);
        current_state = s;
        serve_due = -1;
        tick();
        m_active = 0;
        m_done   = 0;
        m_win    = 0;
        m_lose   = 0;
        if (s == SM) m_score = 0;
        check_state("screen");
    endtask

    task automatic enter_level(input int n);
        current_state = 4'(n + 2);
        m_level   = n;
        m_active  = 1;
        m_done    = 0;
        serve_due = cyc + 2;
        tick();
        check_state("entry_k");      // counters not yet loaded
        tick();
        m_bricks = tbl[n];
        m_lives  = LIVES;
        check_state("entry_k1");
    endtask

    task automatic pulse(input bit h, input bit l);
        int  e;
        bit  in_play;
        bit  counted;
        e = cyc + 1;
        in_play = m_active && !m_done && (e > serve_due);
        brick_hit = h;
        ball_lost = l;
        tick();
        brick_hit = 1'b0;
        ball_lost = 1'b0;
        if (in_play) begin
            counted = h && (m_bricks > 0);
            if (counted) begin
                m_bricks--;
                m_score = (m_score + m_level > SMAX) ? SMAX : m_score + m_level;
            end
            if (counted && m_bricks == 0) begin
                m_win  = 1;
                m_done = 1;
            end else if (l) begin
                m_lives--;
                if (m_lives == 0) begin
                    m_lose = 1;
                    m_done = 1;
                end else begin
                    serve_due = e + 1 + SERVE_DLY;
                end
            end
        end
        check_state("pulse");
    endtask

    task automatic wait_serve();
        int guard;
        guard = 0;
        while (cyc < serve_due && guard < 64) begin
            tick();
            guard++;
        end
        chk("serve_wait_bound", 32'(cyc == serve_due), 32'd1);
    endtask

    // Level FSM reaction: samples the outcome one edge later, then leaves.
    task automatic finish_outcome(input logic [3:0] s);
        tick();
        check_state("outcome_hold");
        set_screen(s);
    endtask

    initial begin
        tbl = '{8, 12, 16, 20, 24, 28, 32, 40};
        reset = 1'b1;
        current_state = SM;
        brick_hit = 1'b0;
        ball_lost = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check_state("reset");

        // Entry at L1
        set_screen(SM);
        enter_level(1);
        set_screen(LS);

        // Win at L3 from a cleared score
        set_screen(SM);
        enter_level(3);
        repeat (16) pulse(1'b1, 1'b0);
        chk("win_score48", 32'(score), 32'd48);
        chk("win_flag", 32'(win), 32'd1);
        finish_outcome(LS);

        // Lose at L2: three losses, serves after the first two only
        enter_level(2);
        repeat (3) begin
            wait_serve();
            pulse(1'b0, 1'b1);
        end
        chk("lose_flag", 32'(lose), 32'd1);
        chk("lose_lives0", 32'(lives), 32'd0);
        repeat (20) tick();          // DONE holds; no serve may appear
        check_state("lose_hold");
        set_screen(GO);

        // Simultaneous last brick and last life at L1
        set_screen(LS);
        enter_level(1);
        repeat (2) begin
            wait_serve();
            pulse(1'b0, 1'b1);
        end
        wait_serve();
        repeat (7) pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        chk("simul_win", 32'(win), 32'd1);
        chk("simul_lose", 32'(lose), 32'd0);
        chk("simul_lives", 32'(lives), 32'd1);
        finish_outcome(LS);

        // Hits during respawn are ignored
        enter_level(4);
        pulse(1'b0, 1'b1);
        repeat (5) pulse(1'b1, 1'b0);
        chk("respawn_bricks", 32'(bricks_left), 32'd20);
        wait_serve();
        pulse(1'b1, 1'b0);
        set_screen(LS);

        // Abort mid-play at L8, then score clear on SM
        enter_level(8);
        repeat (3) pulse(1'b1, 1'b0);
        set_screen(LS);
        chk("abort_bricks", 32'(bricks_left), 32'd37);
        set_screen(SM);
        chk("sm_score", 32'(score), 32'd0);

        // Score saturation: clearing L8 gives 320 > 255
        enter_level(8);
        repeat (40) pulse(1'b1, 1'b0);
        chk("sat_score", 32'(score), 32'(SMAX));
        finish_outcome(LS);

        // Randomised play across random levels
        for (int r = 0; r < 6; r++) begin
            enter_level(int'($urandom_range(1, 8)));
            for (int s = 0; s < 300; s++) begin
                pulse(($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));
                if (m_done) break;
            end
            if (m_done) finish_outcome((m_lose) ? GO : LS);
            else set_screen(($urandom_range(0, 1) == 0) ? LS : SM);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_status.md
# game_status

Tracks per-level play statistics for the Breakout game and produces the `win`/`lose` outcome signals consumed by the screen/level state machine. It watches the level FSM's `current_state` and loads a per-level brick count and life budget on level entry. It counts brick hits and ball losses, accumulates score, and requests a ball serve. It sits between the ball/brick collision logic and the level FSM, and is the producer end of that FSM's `win`/`lose` inputs.

## Interface
Parameters:
- `LIVES`, 3 — lives granted at each level start (1..7).
- `SERVE_DLY`, 16 — cycles between a ball loss and the re-serve (≥1).
- `SCORE_W`, 16 — score width.

Ports:
- `clk` input 1 — single system clock.
- `reset` input 1 — synchronous, active-high.
- `current_state` input 4 — level FSM state encoding.
- `brick_hit` input 1 — one-cycle pulse per brick destroyed.
- `ball_lost` input 1 — one-cycle pulse when the ball passes the paddle.
- `win` output 1 — all bricks cleared; held as defined under Timing.
- `lose` output 1 — last life lost; held as defined under Timing.
- `lives` output 3 — remaining lives.
- `bricks_left` output 6 — bricks remaining in the current level.
- `score` output `SCORE_W` — accumulated score.
- `serve_req` output 1 — one-cycle pulse requesting a new ball serve.

## Operation
- `current_state` encodings:
  - Screens: SM=4'hF, LS=4'h1, GO=4'h2.
  - Levels: L1..L8 = 4'h3..4'hA. Level index n = state−2.
- Internal FSM states: IDLE, LOAD, PLAY, RESPAWN, DONE.
- **IDLE:** `win`=`lose`=0. Goes to LOAD when `current_state` is a level.
- **LOAD:** lasts one cycle.
  - `bricks_left` ← BRICKS[n], using the table L1..L8 = 8, 12, 16, 20, 24, 28, 32, 40. All entries are nonzero.
  - `lives` ← `LIVES`.
  - Then goes to PLAY.
- **PLAY:**
  - `brick_hit`: `bricks_left`−1, and `score` += n, saturating at all-ones. If `bricks_left` was 1, go to DONE with `win`=1.
  - `ball_lost`: `lives`−1. If `lives` was 1, go to DONE with `lose`=1. Otherwise go to RESPAWN.
  - Both pulses in the same cycle: the brick is counted first. If that brick was the last one, `win` takes priority and `lives` is not decremented. Otherwise both updates apply.
- **RESPAWN:**
  - Counts `SERVE_DLY` cycles, then returns to PLAY.
  - `brick_hit` and `ball_lost` are ignored in this state.
- **DONE:** `win`/`lose` are held. Goes to IDLE when `current_state` is not a level.
- **Abort:** in any state, a non-level `current_state` sends the FSM to IDLE next cycle.
  - `win`/`lose` and the respawn counter are cleared.
  - `lives` and `bricks_left` hold their values.
- **Score:**
  - Cleared whenever `current_state`==SM.
  - Retained across levels and through GO, so the game-over screen can display it.
- `bricks_left` never underflows; hits at 0 are ignored.

## Timing
- Reset values:
  - State IDLE.
  - `win`=`lose`=`serve_req`=0.
  - `lives`=0, `bricks_left`=0, `score`=0.
- All outputs are registered. Counter latency is 1 cycle: a pulse sampled at edge k is visible after edge k.
- Level entry:
  - `current_state` becomes a level before edge k.
  - Edge k: FSM enters LOAD.
  - Edge k+1: counters loaded, FSM enters PLAY, and `serve_req`=1 for that one cycle.
- Ball loss with lives remaining:
  - `ball_lost` sampled at edge k.
  - `serve_req` is high in the cycle following edge k+1+`SERVE_DLY`.
- Outcome signals:
  - `win`/`lose` rise after edge k.
  - The level FSM samples them at k+1.
  - They fall after edge k+2, so they are high for exactly 2 cycles in normal flow.
- `win` and `lose` are never high together.
- `serve_req` is never high outside the PLAY state.

## Structure
- Shared package `breakout_pkg` holds:
  - Screen/level encodings (SM, LS, GO, L1..L8), shared with the level FSM.
  - The BRICKS table as a constant function of level index.
  - A function `is_level(state)`.
- This block's FSM encoding is local to the module.
- No sub-module is required. The respawn delay is an inline counter of width clog2(`SERVE_DLY`+1).

## Test plan
- **Reset/entry:** reset, then `current_state`=L1. Expect `bricks_left`=8, `lives`=3, and `serve_req` for 1 cycle two edges after entry.
- **Win:** at L3, send 16 `brick_hit` pulses.
  - Expect `score`=48 and `win`=1 for 2 cycles.
  - Expect `bricks_left`=0 and `lose`=0 throughout.
- **Lose:** at L2, send 3 `ball_lost` pulses, each after its serve.
  - Expect `lives` 3→2→1→0 and `lose`=1.
  - Expect `serve_req` 17 cycles after each of the first two losses, and none after the third.
- **Simultaneous events:** at L1 with `bricks_left`=1 and `lives`=1, assert `brick_hit` and `ball_lost` together. Expect `win`=1, `lose`=0, `lives`=1.
- **RESPAWN filtering:** `brick_hit` pulses during RESPAWN leave `bricks_left` and `score` unchanged.
- **Abort/score clear:** mid-PLAY at L8, drive `current_state`=LS.
  - Expect IDLE next cycle with no `win`/`lose`.
  - Then drive SM and expect `score`=0.
